pid_sample_sequencer: RTL and testbench

- Periodic controller that sequences the single-axis PID core: latches a sensor sample, commits staged gains and setpoint, enables the PID, waits for its ready, then clamps the result and hands it to the servo driver.
- Sits between the sensor/config side and the PID core; one instance per axis.
- Gains and setpoint are double-buffered, so register writes never change PID operands mid-computation.

---
 rtl/pid_sample_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_pid_sample_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pid_sample_sequencer.sv
// Per-axis sample sequencer for the PID core: periodic tick, double-buffered
// operands, bounded wait on the PID result and a signed clamp onto the servo command.
module pid_sample_sequencer #(
    parameter int PERIOD  = 50000,
    parameter int TIMEOUT = 1024,
    parameter int CMD_MAX = 1000,
    parameter int CMD_MIN = -1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    input  logic [15:0] pv_in,
    input  logic        pv_valid,
    output logic [15:0] pid_Kp,
    output logic [15:0] pid_Ki,
    output logic [15:0] pid_Kd,
    output logic [15:0] pid_Sp,
    output logic [15:0] pid_Pv,
    output logic        pid_enable,
    input  logic [15:0] pid_data,
    input  logic        pid_ready,
    output logic [15:0] cmd_out,
    output logic        cmd_valid,
    output logic        busy,
    output logic        timeout_err,
    output logic        overrun
);

    localparam int TW = $clog2(PERIOD);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic signed [15:0] CMD_HI = 16'(CMD_MAX);
    localparam logic signed [15:0] CMD_LO = 16'(CMD_MIN);

    typedef struct packed {
        logic [15:0] kp;
        logic [15:0] ki;
        logic [15:0] kd;
        logic [15:0] sp;
    } operands_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_SAMPLE,
        S_COMPUTE,
        S_OUTPUT
    } state_t;

    state_t            state;
    operands_t         shadow;
    operands_t         active;
    logic [15:0]       pv_hold;
    logic [15:0]       pv_act;
    logic [TW-1:0]     timer;
    logic [CW-1:0]     tcnt;
    logic              ready_q;
    logic              tick;
    logic              ready_edge;
    logic              flag_clr;
    logic signed [15:0] data_s;
    logic signed [15:0] clamped;

    assign pid_Kp = active.kp;
    assign pid_Ki = active.ki;
    assign pid_Kd = active.kd;
    assign pid_Sp = active.sp;
    assign pid_Pv = pv_act;

    assign tick       = run && (timer == TW'(PERIOD - 1));
    assign ready_edge = pid_ready && !ready_q;
    assign flag_clr   = cfg_we && (cfg_addr == 3'd4) && cfg_wdata[0];

    always_comb begin
        data_s = pid_data;
        if (data_s > CMD_HI)
            clamped = CMD_HI;
        else if (data_s < CMD_LO)
            clamped = CMD_LO;
        else
            clamped = data_s;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer   <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= pid_ready;
            if (!run || tick)
                timer <= '0;
            else
                timer <= timer + TW'(1);
        end
    end

    // Staging side: writes and pv updates land here and only reach the PID in SAMPLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow  <= '0;
            pv_hold <= '0;
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    3'd0:    shadow.kp <= cfg_wdata;
                    3'd1:    shadow.ki <= cfg_wdata;
                    3'd2:    shadow.kd <= cfg_wdata;
                    3'd3:    shadow.sp <= cfg_wdata;
                    default: ;
                endcase
            end
            if (pv_valid)
                pv_hold <= pv_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            active      <= '0;
            pv_act      <= '0;
            tcnt        <= '0;
            pid_enable  <= 1'b0;
            cmd_out     <= '0;
            cmd_valid   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            cmd_valid <= 1'b0;
            // Flag sets are placed after the clear so a same-cycle event is never lost.
            if (flag_clr) begin
                timeout_err <= 1'b0;
                overrun     <= 1'b0;
            end
            if (tick && busy)
                overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (run)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!run) begin
                        state <= S_IDLE;
                    end else if (tick) begin
                        state <= S_SAMPLE;
                        busy  <= 1'b1;
                    end
                end
                S_SAMPLE: begin
                    active     <= shadow;
                    pv_act     <= pv_hold;
                    pid_enable <= 1'b1;
                    tcnt       <= '0;
                    state      <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    // Result is clamped on capture so the command appears in the OUTPUT cycle.
                    if (ready_edge) begin
                        pid_enable <= 1'b0;
                        cmd_out    <= clamped;
                        cmd_valid  <= 1'b1;
                        state      <= S_OUTPUT;
                    end else if (tcnt == CW'(TIMEOUT - 1)) begin
                        pid_enable  <= 1'b0;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= run ? S_WAIT : S_IDLE;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                S_OUTPUT: begin
                    busy  <= 1'b0;
                    state <= run ? S_WAIT : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pid_sample_sequencer.sv
// Directed + randomized bench for pid_sample_sequencer; expected timing comes from
// the tick schedule and busy windows, expected values from shadow/pv/clamp models.
module tb_pid_sample_sequencer;

    localparam int P    = 8;
    localparam int TO   = 12;
    localparam int CMAX = 1000;
    localparam int CMIN = -1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [15:0] cfg_wdata = '0;
    logic [15:0] pv_in = '0;
    logic        pv_valid = 1'b0;
    logic [15:0] pid_Kp, pid_Ki, pid_Kd, pid_Sp, pid_Pv;
    logic        pid_enable;
    logic [15:0] pid_data = '0;
    logic        pid_ready = 1'b0;
    logic [15:0] cmd_out;
    logic        cmd_valid, busy, timeout_err, overrun;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int base = 0;
    int last_end = 0;
    logic [15:0] sh [4];
    logic [15:0] pv_m, cmd_m;
    bit tout_m, ovr_m;

    pid_sample_sequencer #(.PERIOD(P), .TIMEOUT(TO), .CMD_MAX(CMAX), .CMD_MIN(CMIN)) dut (
        .clk(clk), .reset(reset), .run(run), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .pv_in(pv_in), .pv_valid(pv_valid),
        .pid_Kp(pid_Kp), .pid_Ki(pid_Ki), .pid_Kd(pid_Kd), .pid_Sp(pid_Sp), .pid_Pv(pid_Pv),
        .pid_enable(pid_enable), .pid_data(pid_data), .pid_ready(pid_ready),
        .cmd_out(cmd_out), .cmd_valid(cmd_valid), .busy(busy),
        .timeout_err(timeout_err), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] clampf(input logic [15:0] d);
        int v;
        v = int'($signed(d));
        if (v > CMAX) v = CMAX;
        else if (v < CMIN) v = CMIN;
        return 16'(v);
    endfunction

    // Ticks fall on base+P-1+m*P; returns the first one strictly after cycle x.
    function automatic int next_tick(input int x);
        int f;
        f = base + P - 1;
        if (x < f) return f;
        return f + ((x - f) / P + 1) * P;
    endfunction

    task automatic drive(input bit we, input logic [2:0] a, input logic [15:0] d,
                         input bit pvv, input logic [15:0] p);
        cfg_we = we; cfg_addr = a; cfg_wdata = d; pv_valid = pvv; pv_in = p;
        step();
        cfg_we = 1'b0; pv_valid = 1'b0;
        if (we && a < 3'd4) sh[a[1:0]] = d;
        if (we && a == 3'd4 && d[0]) begin tout_m = 0; ovr_m = 0; end
        if (pvv) pv_m = p;
    endtask

    // One control sample; lat<0 means the PID never answers.
    task automatic run_sample(input int lat, input logic [15:0] data, input bit in_wr,
                              input logic [2:0] wa, input logic [15:0] wd, input bit drop_run);
        int t_exp, n, e, en_cnt, vcnt, last_busy;
        logic [15:0] snap [4];
        logic [15:0] pv_snap;
        t_exp = next_tick(last_end);
        n = 0;
        while (busy !== 1'b1 && n < 4 * P + 8) begin step(); n++; end
        chk("sample_cycle", cyc, t_exp + 1);
        snap = sh;
        pv_snap = pv_m;
        if (in_wr) drive(1'b1, wa, wd, 1'b1, 16'($urandom));
        else step();
        e = cyc;
        chk("en_on", pid_enable, 1'b1);
        chk("op_Kp", pid_Kp, snap[0]);
        chk("op_Ki", pid_Ki, snap[1]);
        chk("op_Kd", pid_Kd, snap[2]);
        chk("op_Sp", pid_Sp, snap[3]);
        chk("op_Pv", pid_Pv, pv_snap);
        if (drop_run) run = 1'b0;
        en_cnt = 0; vcnt = 0;
        if (lat >= 0) begin
            for (int k = 0; k < lat; k++) begin
                en_cnt += int'(pid_enable); vcnt += int'(cmd_valid); step();
            end
            en_cnt += int'(pid_enable); vcnt += int'(cmd_valid);
            pid_ready = 1'b1; pid_data = data;
            step();
            pid_ready = 1'b0; pid_data = 16'($urandom);
            cmd_m = clampf(data);
            chk("en_width", en_cnt, lat + 1);
            chk("no_early_valid", vcnt, 0);
            chk("valid_pulse", cmd_valid, 1'b1);
            chk("cmd_out", cmd_out, cmd_m);
            chk("en_off", pid_enable, 1'b0);
            last_busy = e + lat + 1;
            step();
            chk("valid_one_cycle", cmd_valid, 1'b0);
        end else begin
            for (int k = 0; k < TO; k++) begin
                en_cnt += int'(pid_enable); vcnt += int'(cmd_valid); step();
            end
            tout_m = 1;
            last_busy = e + TO - 1;
            chk("to_en_width", en_cnt, TO);
            chk("to_no_valid", vcnt + int'(cmd_valid), 0);
            chk("to_en_off", pid_enable, 1'b0);
            chk("to_cmd_hold", cmd_out, cmd_m);
        end
        if (!drop_run && t_exp + P <= last_busy) ovr_m = 1;
        chk("busy_done", busy, 1'b0);
        chk("timeout_err", timeout_err, tout_m);
        chk("overrun", overrun, ovr_m);
        last_end = last_busy;
    endtask

    initial begin
        int bcnt, n, l;
        foreach (sh[i]) sh[i] = '0;
        pv_m = '0; cmd_m = '0; tout_m = 0; ovr_m = 0;
        #1 reset = 1'b0;
        step(); step();
        chk("rst_cmd", cmd_out, 16'h0);
        chk("rst_valid", cmd_valid, 1'b0);
        chk("rst_en", pid_enable, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_flags", {timeout_err, overrun}, 2'b00);
        chk("rst_ops", {pid_Kp, pid_Pv}, 32'h0);
        reset = 1'b1;

        drive(1'b1, 3'd0, 16'd5, 1'b0, 16'h0);
        drive(1'b1, 3'd1, 16'($urandom), 1'b0, 16'h0);
        drive(1'b1, 3'd2, 16'($urandom), 1'b0, 16'h0);
        drive(1'b1, 3'd3, 16'd500, 1'b1, 16'd100);
        bcnt = 0;
        repeat (2 * P) begin bcnt += int'(busy) + int'(pid_enable); step(); end
        chk("idle_no_run", bcnt, 0);

        run = 1'b1; base = cyc; last_end = cyc;
        run_sample(3, 16'd400, 0, 3'd0, 16'h0, 0);
        run_sample(3, 16'd400, 0, 3'd0, 16'h0, 0);
        run_sample(2, 16'd2500, 0, 3'd0, 16'h0, 0);
        run_sample(1, 16'h8000, 0, 3'd0, 16'h0, 0);
        run_sample(0, 16'(-999), 0, 3'd0, 16'h0, 0);
        run_sample(TO - 1, 16'd1000, 0, 3'd0, 16'h0, 0);
        run_sample(2, 16'(-1000), 1, 3'd0, 16'd9, 0);
        drive(1'b1, 3'd5, 16'hBEEF, 1'b0, 16'h0);
        run_sample(2, 16'd123, 0, 3'd0, 16'h0, 0);

        run_sample(-1, 16'h0, 0, 3'd0, 16'h0, 0);
        drive(1'b1, 3'd4, 16'h0002, 1'b0, 16'h0);
        chk("noclr_flags", {timeout_err, overrun}, 2'b11);
        drive(1'b1, 3'd4, 16'h0001, 1'b0, 16'h0);
        chk("clr_flags", {timeout_err, overrun}, 2'b00);
        run_sample(6, 16'd555, 0, 3'd0, 16'h0, 0);

        run_sample(2, 16'd200, 0, 3'd0, 16'h0, 1);
        bcnt = 0;
        repeat (2 * P) begin bcnt += int'(busy) + int'(pid_enable); step(); end
        chk("idle_after_drop", bcnt, 0);
        run = 1'b1; base = cyc; last_end = cyc;

        for (int i = 0; i < 24; i++) begin
            l = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO - 1));
            run_sample(l, ($urandom_range(0, 2) == 0) ? 16'($urandom)
                                                     : 16'(int'($urandom_range(0, 2400)) - 1200),
                       0, 3'd0, 16'h0, 0);
            drive(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)),
                  16'($urandom));
        end

        run_sample(-1, 16'h0, 0, 3'd0, 16'h0, 0);
        run_sample(6, 16'd321, 0, 3'd0, 16'h0, 0);
        n = 0;
        while (pid_enable !== 1'b1 && n < 4 * P + 8) begin step(); n++; end
        chk("abort_in_compute", pid_enable, 1'b1);
        step();
        #2 reset = 1'b0;
        #1;
        chk("arst_cmd", cmd_out, 16'h0);
        chk("arst_en", pid_enable, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_flags", {timeout_err, overrun}, 2'b00);
        step();
        chk("arst_valid", cmd_valid, 1'b0);
        step();
        reset = 1'b1;
        foreach (sh[i]) sh[i] = '0;
        pv_m = '0; cmd_m = '0; tout_m = 0; ovr_m = 0;
        base = cyc; last_end = cyc;
        run_sample(2, 16'd77, 0, 3'd0, 16'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
